// File: rtl/axi_reg_bridge.sv
// axi_reg_bridge: 64-bit AXI-Lite style slave that turns each write/read
// transaction into a single-cycle strobe towards a register manager.
// Write and read paths are independent state machines.
// Optional macro REG_ADDR_ALIGN_CHECK_EN: AW/AR addresses that are not
// 8-byte aligned are rejected with SLVERR and never reach the register manager.
module axi_reg_bridge #(
  parameter int RD_LATENCY = 1,  // o_reg_ren to i_reg_rdata valid, 1..7
  parameter int ADDR_W     = 16  // AXI address width, at least 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [63:0]       s_axi_wdata,
  input  logic [7:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [63:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              o_reg_wen,
  output logic [15:0]       o_reg_waddr,
  output logic [63:0]       o_reg_wdata,
  output logic              o_reg_ren,
  output logic [15:0]       o_reg_raddr,
  input  logic [63:0]       i_reg_rdata
);

  localparam logic [2:0] RD_LAST = 3'(RD_LATENCY - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} rstate_t;

  // Write path state
  wstate_t     r_wstate;
  logic        r_aw_full, r_w_full;
  logic [15:0] r_awaddr;
  logic [63:0] r_wdata;
  logic [7:0]  r_wstrb;
  logic        r_awready, r_wready, r_bvalid;
  logic [1:0]  r_bresp;
  logic        r_reg_wen;
  logic [15:0] r_reg_waddr;
  logic [63:0] r_reg_wdata;

  // Read path state
  rstate_t     r_rstate;
  logic        r_arready, r_rvalid, r_rd_err;
  logic [2:0]  r_rcnt;
  logic [63:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        r_reg_ren;
  logic [15:0] r_reg_raddr;

  // Handshakes and "latched or arriving now" selections
  logic        w_aw_hs, w_w_hs, w_ar_hs;
  logic        w_aw_have, w_w_have;
  logic [15:0] w_awaddr_sel;
  logic [63:0] w_wdata_sel;
  logic [7:0]  w_wstrb_sel;
  logic        w_aw_misalign, w_ar_misalign, w_wr_ok;

  assign w_aw_hs      = s_axi_awvalid & r_awready;
  assign w_w_hs       = s_axi_wvalid & r_wready;
  assign w_ar_hs      = s_axi_arvalid & r_arready;
  assign w_aw_have    = r_aw_full | w_aw_hs;
  assign w_w_have     = r_w_full | w_w_hs;
  assign w_awaddr_sel = w_aw_hs ? s_axi_awaddr[15:0] : r_awaddr;
  assign w_wdata_sel  = w_w_hs ? s_axi_wdata : r_wdata;
  assign w_wstrb_sel  = w_w_hs ? s_axi_wstrb : r_wstrb;

`ifdef REG_ADDR_ALIGN_CHECK_EN
  assign w_aw_misalign = (w_awaddr_sel[2:0] != 3'd0);
  assign w_ar_misalign = (s_axi_araddr[2:0] != 3'd0);
`else
  assign w_aw_misalign = 1'b0;
  assign w_ar_misalign = 1'b0;
`endif

  // Only full-word, acceptable writes reach the register manager
  assign w_wr_ok = (w_wstrb_sel == 8'hFF) && !w_aw_misalign;

  // Write FSM: collect AW and W in any order, issue one strobe, then respond
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate    <= W_IDLE;
      r_aw_full   <= 1'b0;
      r_w_full    <= 1'b0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bresp     <= RESP_OKAY;
      r_reg_wen   <= 1'b0;
      r_reg_waddr <= '0;
      r_reg_wdata <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_aw_full <= 1'b1;
            r_awaddr  <= s_axi_awaddr[15:0];
          end
          if (w_w_hs) begin
            r_w_full <= 1'b1;
            r_wdata  <= s_axi_wdata;
            r_wstrb  <= s_axi_wstrb;
          end
          if (w_aw_have && w_w_have) begin
            r_wstate    <= W_ISSUE;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_reg_wen   <= w_wr_ok;
            r_reg_waddr <= w_awaddr_sel;
            r_reg_wdata <= w_wdata_sel;
            r_bresp     <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
          end else begin
            // Each ready stays up until its own channel has been captured
            r_awready <= !w_aw_have;
            r_wready  <= !w_w_have;
          end
        end
        W_ISSUE: begin
          r_reg_wen <= 1'b0;
          r_bvalid  <= 1'b1;
          r_wstate  <= W_RESP;
        end
        W_RESP: begin
          if (s_axi_bready) begin
            r_bvalid  <= 1'b0;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read FSM: accept AR, strobe once, wait RD_LATENCY cycles, then respond
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate    <= R_IDLE;
      r_arready   <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rd_err    <= 1'b0;
      r_rcnt      <= '0;
      r_rdata     <= '0;
      r_rresp     <= RESP_OKAY;
      r_reg_ren   <= 1'b0;
      r_reg_raddr <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_arready   <= 1'b0;
            r_reg_raddr <= s_axi_araddr[15:0];
            r_reg_ren   <= !w_ar_misalign;
            r_rd_err    <= w_ar_misalign;
            r_rstate    <= R_ISSUE;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_ISSUE: begin
          r_reg_ren <= 1'b0;
          r_rcnt    <= '0;
          r_rstate  <= R_WAIT;
        end
        R_WAIT: begin
          if (r_rcnt == RD_LAST) begin
            r_rdata  <= r_rd_err ? 64'd0 : i_reg_rdata;
            r_rresp  <= r_rd_err ? RESP_SLVERR : RESP_OKAY;
            r_rvalid <= 1'b1;
            r_rstate <= R_RESP;
          end else begin
            r_rcnt <= r_rcnt + 3'd1;
          end
        end
        R_RESP: begin
          if (s_axi_rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign o_reg_wen     = r_reg_wen;
  assign o_reg_waddr   = r_reg_waddr;
  assign o_reg_wdata   = r_reg_wdata;
  assign o_reg_ren     = r_reg_ren;
  assign o_reg_raddr   = r_reg_raddr;

endmodule

// File: tb/tb_axi_reg_bridge.sv
// tb_axi_reg_bridge: directed and randomized transactions on axi_reg_bridge,
// checked against a register-level reference model (expected register
// contents, strobe counts, responses and cycle latencies).
module tb_axi_reg_bridge;
  localparam int RD_LATENCY = 1;
  localparam int ADDR_W     = 16;
`ifdef REG_ADDR_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] s_axi_awaddr = '0;
  logic              s_axi_awvalid = 1'b0;
  logic              s_axi_awready;
  logic [63:0]       s_axi_wdata = '0;
  logic [7:0]        s_axi_wstrb = '0;
  logic              s_axi_wvalid = 1'b0;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready = 1'b0;
  logic [ADDR_W-1:0] s_axi_araddr = '0;
  logic              s_axi_arvalid = 1'b0;
  logic              s_axi_arready;
  logic [63:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready = 1'b0;
  logic              o_reg_wen;
  logic [15:0]       o_reg_waddr;
  logic [63:0]       o_reg_wdata;
  logic              o_reg_ren;
  logic [15:0]       o_reg_raddr;
  logic [63:0]       i_reg_rdata;

  always #5 clk = ~clk;

  axi_reg_bridge #(.RD_LATENCY(RD_LATENCY), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .o_reg_wen(o_reg_wen), .o_reg_waddr(o_reg_waddr), .o_reg_wdata(o_reg_wdata),
    .o_reg_ren(o_reg_ren), .o_reg_raddr(o_reg_raddr), .i_reg_rdata(i_reg_rdata)
  );

  // Register-manager emulation: storage written by strobes, read data returned
  // exactly RD_LATENCY cycles after o_reg_ren, garbage at all other times.
  logic [63:0] rm_mem [logic [15:0]];
  logic [63:0] rm_pipe [RD_LATENCY];
  logic        rm_pv   [RD_LATENCY];
  int          wen_cnt = 0;
  int          ren_cnt = 0;

  initial begin
    for (int i = 0; i < RD_LATENCY; i++) begin
      rm_pv[i]   = 1'b0;
      rm_pipe[i] = 64'd0;
    end
  end

  always @(posedge clk) begin
    for (int i = RD_LATENCY - 1; i > 0; i--) begin
      rm_pipe[i] <= rm_pipe[i-1];
      rm_pv[i]   <= rm_pv[i-1];
    end
    rm_pv[0]   <= o_reg_ren;
    rm_pipe[0] <= (o_reg_ren && rm_mem.exists(o_reg_raddr)) ? rm_mem[o_reg_raddr] : 64'd0;
    if (o_reg_wen) begin
      rm_mem[o_reg_waddr] = o_reg_wdata;
      wen_cnt++;
    end
    if (o_reg_ren) ren_cnt++;
  end

  assign i_reg_rdata = rm_pv[RD_LATENCY-1] ? rm_pipe[RD_LATENCY-1] : 64'hBAD0_BAD1_BAD2_BAD3;

  // Reference model: what the register file should hold after each transaction
  logic [63:0] ref_mem [logic [15:0]];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic bit addr_ok(input logic [15:0] a);
    return !(ALIGN_CHK && (a[2:0] != 3'd0));
  endfunction

  function automatic logic [63:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 64'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [63:0] data, input logic [7:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit         aw_done, w_done, aw_hs, w_hs, exp_wen;
    int         t, w0;
    logic [1:0] exp_bresp;
    aw_done = 0; w_done = 0; t = 0;
    exp_wen   = (strb == 8'hFF) && addr_ok(addr);
    exp_bresp = exp_wen ? 2'b00 : 2'b10;
    w0 = wen_cnt;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    while (!(aw_done && w_done) && t < 40) begin
      s_axi_awvalid = !aw_done && (t >= aw_dly);
      s_axi_wvalid  = !w_done && (t >= w_dly);
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      step();
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      t++;
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    chk("wr_accept", 64'(aw_done && w_done), 64'd1);
    // Cycle after the completing handshake: the strobe cycle
    chk("wr_wen", 64'(o_reg_wen), 64'(exp_wen));
    if (exp_wen) begin
      chk("wr_waddr", 64'(o_reg_waddr), 64'(addr));
      chk("wr_wdata", o_reg_wdata, data);
    end
    chk("wr_busy_awready", 64'(s_axi_awready), 64'd0);
    chk("wr_busy_wready", 64'(s_axi_wready), 64'd0);
    chk("wr_bvalid_early", 64'(s_axi_bvalid), 64'd0);
    step();
    chk("wr_bvalid", 64'(s_axi_bvalid), 64'd1);
    chk("wr_bresp", 64'(s_axi_bresp), 64'(exp_bresp));
    chk("wr_wen_single", 64'(o_reg_wen), 64'd0);
    for (int i = 0; i < b_dly; i++) begin
      step();
      chk("wr_bhold", 64'({s_axi_bvalid, s_axi_bresp}), 64'({1'b1, exp_bresp}));
    end
    s_axi_bready = 1;
    step();
    s_axi_bready = 0;
    chk("wr_bdone", 64'(s_axi_bvalid), 64'd0);
    chk("wr_ready_back", 64'({s_axi_awready, s_axi_wready}), 64'd3);
    chk("wr_wen_count", 64'(wen_cnt - w0), 64'(exp_wen));
    if (exp_wen) ref_mem[addr] = data;
    $display("[TB] write addr=%h data=%h strb=%h bresp=%0d", addr, data, strb, exp_bresp);
  endtask

  task automatic do_read(input logic [15:0] addr, input int r_dly);
    bit          hs, exp_ren;
    int          t, r0;
    logic [63:0] exp_data;
    logic [1:0]  exp_resp;
    hs = 0; t = 0;
    exp_ren  = addr_ok(addr);
    exp_data = exp_ren ? ref_read(addr) : 64'd0;
    exp_resp = exp_ren ? 2'b00 : 2'b10;
    r0 = ren_cnt;
    s_axi_araddr = addr; s_axi_arvalid = 1;
    while (!hs && t < 40) begin
      hs = s_axi_arready;
      step();
      t++;
    end
    s_axi_arvalid = 0;
    chk("rd_accept", 64'(hs), 64'd1);
    chk("rd_ren", 64'(o_reg_ren), 64'(exp_ren));
    if (exp_ren) chk("rd_raddr", 64'(o_reg_raddr), 64'(addr));
    chk("rd_busy_arready", 64'(s_axi_arready), 64'd0);
    chk("rd_rvalid_early", 64'(s_axi_rvalid), 64'd0);
    for (int i = 0; i < RD_LATENCY; i++) begin
      step();
      chk("rd_rvalid_wait", 64'(s_axi_rvalid), 64'd0);
      chk("rd_ren_single", 64'(o_reg_ren), 64'd0);
    end
    step();
    chk("rd_rvalid", 64'(s_axi_rvalid), 64'd1);
    chk("rd_rdata", s_axi_rdata, exp_data);
    chk("rd_rresp", 64'(s_axi_rresp), 64'(exp_resp));
    for (int i = 0; i < r_dly; i++) begin
      step();
      chk("rd_hold_valid", 64'(s_axi_rvalid), 64'd1);
      chk("rd_hold_data", s_axi_rdata, exp_data);
      chk("rd_hold_resp", 64'(s_axi_rresp), 64'(exp_resp));
    end
    s_axi_rready = 1;
    step();
    s_axi_rready = 0;
    chk("rd_done", 64'(s_axi_rvalid), 64'd0);
    chk("rd_ready_back", 64'(s_axi_arready), 64'd1);
    chk("rd_ren_count", 64'(ren_cnt - r0), 64'(exp_ren));
    $display("[TB] read  addr=%h data=%h rresp=%0d", addr, exp_data, exp_resp);
  endtask

  initial begin
    logic [15:0] a;
    logic [63:0] d;
    logic [7:0]  s;
    int          c0;

    // Reset state
    repeat (3) step();
    chk("rst_ready", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'd0);
    chk("rst_valid", 64'({s_axi_bvalid, s_axi_rvalid}), 64'd0);
    chk("rst_resp", 64'({s_axi_bresp, s_axi_rresp}), 64'd0);
    chk("rst_rdata", s_axi_rdata, 64'd0);
    chk("rst_strobes", 64'({o_reg_wen, o_reg_ren}), 64'd0);
    chk("rst_waddr", 64'(o_reg_waddr), 64'd0);
    chk("rst_wdata", o_reg_wdata, 64'd0);
    chk("rst_raddr", 64'(o_reg_raddr), 64'd0);
    rst_n = 1;
    chk("rst_ready_low_at_release", 64'(s_axi_awready), 64'd0);
    step();
    chk("rst_ready_rise", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'd7);

    // AW and W together
    do_write(16'h0108, 64'h0000_0000_8000_0000, 8'hFF, 0, 0, 0);
    // W three cycles ahead of AW
    do_write(16'h0100, 64'h1122_3344_5566_7788, 8'hFF, 3, 0, 1);
    // AW ahead of W
    do_write(16'h0118, 64'hCAFE_F00D_0BAD_BEEF, 8'hFF, 0, 2, 2);
    // Partial strobe rejected
    do_write(16'h0110, 64'hFFFF_0000_FFFF_0000, 8'h0F, 0, 0, 0);
    do_read(16'h0110, 0);
    // Read with back-pressure
    do_write(16'h0200, 64'h0003_0010_0000_1000, 8'hFF, 0, 0, 0);
    do_read(16'h0200, 5);
    do_read(16'h0108, 1);
    // Unaligned read: forwarded or rejected depending on the build
    do_read(16'h0104, 0);

    // Write and read strobes in the same cycle
    s_axi_awaddr = 16'h0300; s_axi_wdata = 64'h0123_4567_89AB_CDEF; s_axi_wstrb = 8'hFF;
    s_axi_araddr = 16'h0108;
    s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_arvalid = 1;
    step();
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    chk("both_strobes", 64'({o_reg_wen, o_reg_ren}), 64'd3);
    s_axi_bready = 1; s_axi_rready = 1;
    repeat (RD_LATENCY + 3) step();
    s_axi_bready = 0; s_axi_rready = 0;
    chk("both_done", 64'({s_axi_bvalid, s_axi_rvalid}), 64'd0);
    chk("both_rdata", s_axi_rdata, ref_read(16'h0108));
    ref_mem[16'h0300] = 64'h0123_4567_89AB_CDEF;
    $display("[TB] concurrent write 0300 / read 0108");

    // Randomized mix over a small address window
    for (int i = 0; i < 60; i++) begin
      a = {8'h05, 5'($urandom_range(0, 7)), 3'b000};
      if ($urandom_range(0, 5) == 0) a[2:0] = 3'($urandom_range(1, 7));
      d = {$urandom, $urandom};
      s = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hFF;
      if ($urandom_range(0, 1) == 1)
        do_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      else
        do_read(a, int'($urandom_range(0, 3)));
    end

    // Reset with a write in its response phase and a read waiting on data
    s_axi_awaddr = 16'h0400; s_axi_wdata = 64'h5555_AAAA_5555_AAAA; s_axi_wstrb = 8'hFF;
    s_axi_awvalid = 1; s_axi_wvalid = 1;
    step();
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    ref_mem[16'h0400] = 64'h5555_AAAA_5555_AAAA;
    step();
    chk("pre_rst_bvalid", 64'(s_axi_bvalid), 64'd1);
    s_axi_araddr = 16'h0108; s_axi_arvalid = 1;
    step();
    s_axi_arvalid = 0;
    chk("pre_rst_ren", 64'(o_reg_ren), 64'd1);
    step();
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 64'({s_axi_bvalid, s_axi_rvalid}), 64'd0);
    chk("mid_rst_ready", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'd0);
    chk("mid_rst_rdata", s_axi_rdata, 64'd0);
    chk("mid_rst_strobes", 64'({o_reg_wen, o_reg_ren}), 64'd0);
    c0 = wen_cnt + ren_cnt;
    repeat (3) step();
    chk("mid_rst_no_strobe", 64'(wen_cnt + ren_cnt - c0), 64'd0);
    chk("mid_rst_valid_hold", 64'({s_axi_bvalid, s_axi_rvalid}), 64'd0);
    rst_n = 1;
    step();
    chk("post_rst_ready", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'd7);
    chk("post_rst_valid", 64'({s_axi_bvalid, s_axi_rvalid}), 64'd0);
    $display("[TB] reset during write response and read wait");
    do_write(16'h0000, 64'hDEAD_BEEF_0000_0001, 8'hFF, 0, 1, 0);
    do_read(16'h0000, 1);
    do_read(16'h0400, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_reg_bridge.md
AXI_REG_BRIDGE -- requirements
Module: axi_reg_bridge

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1, meaning cycles from o_reg_ren high to i_reg_rdata valid (1..7).
REQ-002 SHALL have parameter ADDR_W, default 16, meaning AXI and register address width.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 s_axi_awaddr  in  ADDR_W  write address.
REQ-006 s_axi_awvalid / s_axi_awready  in / out  1  AW handshake.
REQ-007 s_axi_wdata  in  64  write data.
REQ-008 s_axi_wstrb  in  8  byte strobes.
REQ-009 s_axi_wvalid / s_axi_wready  in / out  1  W handshake.
REQ-010 s_axi_bresp  out  2  write response, 00 OKAY, 10 SLVERR.
REQ-011 s_axi_bvalid / s_axi_bready  out / in  1  B handshake.
REQ-012 s_axi_araddr  in  ADDR_W  read address.
REQ-013 s_axi_arvalid / s_axi_arready  in / out  1  AR handshake.
REQ-014 s_axi_rdata  out  64  read data.
REQ-015 s_axi_rresp  out  2  read response.
REQ-016 s_axi_rvalid / s_axi_rready  out / in  1  R handshake.
REQ-017 o_reg_wen  out  1  one-cycle register write strobe to the register manager.
REQ-018 o_reg_waddr / o_reg_wdata  out  16 / 64  write address and data, valid while o_reg_wen is high.
REQ-019 o_reg_ren  out  1  one-cycle register read strobe.
REQ-020 o_reg_raddr  out  16  read address, valid while o_reg_ren is high.
REQ-021 i_reg_rdata  in  64  registered read data, valid RD_LATENCY cycles after o_reg_ren.

Function
REQ-022 Write path FSM states SHALL be W_IDLE, W_ISSUE, W_RESP; read path FSM states SHALL be R_IDLE, R_ISSUE, R_WAIT, R_RESP; both paths SHALL be fully independent.
REQ-023 In W_IDLE, awready and wready SHALL each be high until their channel is captured; AW and W SHALL be accepted in either order or in the same cycle, each held in its own latch.
REQ-024 W_IDLE to W_ISSUE SHALL occur on the edge where both latches are full; o_reg_wen SHALL be high for exactly the one W_ISSUE cycle.
REQ-025 When wstrb != 8'hFF, W_ISSUE SHALL keep o_reg_wen low and set bresp = 10; otherwise bresp = 00.
REQ-026 W_RESP SHALL hold bvalid high and bresp stable until bready, then return to W_IDLE; no new AW/W SHALL be accepted outside W_IDLE.
REQ-027 In R_IDLE, arready SHALL be high; an AR handshake SHALL latch araddr and enter R_ISSUE, where o_reg_ren is high for exactly one cycle.
REQ-028 R_WAIT SHALL count RD_LATENCY cycles after the R_ISSUE cycle, capture i_reg_rdata into s_axi_rdata on the last of them, then enter R_RESP.
REQ-029 R_RESP SHALL hold rvalid, rdata and rresp = 00 stable until rready, then return to R_IDLE.
REQ-030 Latency SHALL be as follows: write completion edge N gives o_reg_wen in cycle N+1 and bvalid from cycle N+2; AR handshake edge N gives o_reg_ren in cycle N+1 and rvalid from cycle N+2+RD_LATENCY.
REQ-031 Simultaneous o_reg_wen and o_reg_ren SHALL be permitted in the same cycle.
REQ-032 Addresses SHALL be passed through as their low 16 bits, unmodified.

Reset
REQ-033 While rst_n is low, both FSMs SHALL be in idle, the latches SHALL be empty, and the following outputs SHALL be 0: awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, o_reg_wen, o_reg_ren, o_reg_waddr, o_reg_wdata, o_reg_raddr.
REQ-034 Reset asserted mid-transaction SHALL drop the transaction with no response; ready signals SHALL rise in the first cycle after rst_n deasserts.

Configuration
REQ-035 With macro REG_ADDR_ALIGN_CHECK_EN defined, any AW or AR address with bits [2:0] != 0 SHALL suppress o_reg_wen/o_reg_ren and return SLVERR (10), with rdata = 0 for reads; without the macro, addresses SHALL be forwarded unchecked.

Verification
REQ-036 Scenario: AW 0x0108 and W 0x0000_0000_8000_0000 (strb FF) in the same cycle -> one o_reg_wen pulse with waddr 0x0108 and that data, then bresp 00.
REQ-037 Scenario: W presented 3 cycles before AW 0x0100 -> a single o_reg_wen pulse after AW is accepted, then bvalid.
REQ-038 Scenario: wstrb 0x0F to 0x0110 -> no o_reg_wen pulse, bresp 10.
REQ-039 Scenario: AR 0x0200 with RD_LATENCY=1 and model returning 0x0003_0010_0000_1000 -> o_reg_ren pulse then rdata equal to that value, rresp 00; rready held low 5 cycles -> rvalid and rdata stay stable throughout.
REQ-040 Scenario: rst_n low while in W_RESP and R_WAIT -> bvalid and rvalid are 0 and there are no strobes; after release, a fresh write to 0x0000 completes normally.
REQ-041 Scenario: with REG_ADDR_ALIGN_CHECK_EN defined, AR 0x0104 -> no o_reg_ren pulse, rresp 10, rdata 0.
